multi_counter_sched: RTL and testbench
======================================

# multi_counter_sched

Front-end scheduler for the multi-counter block. It arbitrates R independent requesters onto the counter's single command port using round-robin order. After reset or a clear request, it sequences a bulk initialisation of all N counters. It routes each query response back to the requester that issued it, using a fixed-latency tag pipeline. It sits between client logic and any multi-counter implementation whose query response latency is fixed.

## Interface
Parameters:
- W, 32, counter data width
- N, 32, number of counters; id width IW = $clog2(N)
- R, 4, number of requesters; index width RW = $clog2(R) (min 1)
- RSP_LAT, 5, cycles from cmd_pass high to rsp_pass high for OP_QRY (5 for the pipelined SRAM counter, 1 for flop counters)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- clr  in  1  single-cycle pulse; re-initialise all counters
- req_valid  in  R  per-requester command valid
- req_ready  out  R  per-requester accept, combinational from req_valid and state
- req_op  in  R x op_t  per-requester op (multi_counter_variants_pkg::op_t)
- req_id  in  R x IW  per-requester counter id
- req_dat  in  R x W  per-requester data (OP_INIT only)
- cmd_pass  out  1  registered command strobe to counter
- cmd_op  out  op_t  registered op
- cmd_id  out  IW  registered id
- cmd_dat  out  W  registered data
- rsp_pass  in  1  counter response strobe
- rsp_dat  in  W  counter response data
- rsp_valid_r  out  R  one-hot response strobe to owning requester
- rsp_dat_r  out  W  response data, valid when any rsp_valid_r bit is high
- busy_r  out  1  high while in INIT
- err_r  out  1  sticky: rsp_pass without expected tag, or expected tag without rsp_pass

## Operation
- FSM states: INIT and RUN. Reset enters INIT with init id = 0.
- INIT behaviour:
  - Each cycle, issue OP_INIT to the current id with dat = 0, then increment the id.
  - After issuing id N-1, go to RUN.
  - req_ready = 0 throughout.
  - clr in INIT restarts the walk at id 0.
- RUN behaviour:
  - The grant goes to the first requester with req_valid high, searching from (last_grant+1) mod R upward with wrap.
  - At most one grant per cycle; req_ready is one-hot or zero.
  - last_grant updates only on a transfer (valid & ready). Its reset value is R-1, so requester 0 has first priority.
  - A transfer registers op/id/dat onto the cmd_* outputs the next cycle with cmd_pass = 1.
  - clr in RUN goes to INIT at the next edge with init id 0. No grant is issued in the clr cycle.
  - In-flight query responses are still routed normally.
- Tag pipeline: an RSP_LAT-deep shift register of {qry, requester index}.
  - It is loaded alongside cmd_*; qry = 1 only for a granted OP_QRY. INIT-walk commands load qry = 0.
  - The stage-RSP_LAT entry aligns with rsp_pass.
- Response routing:
  - rsp_pass & head.qry: next cycle, rsp_valid_r = one-hot(head.idx) and rsp_dat_r = rsp_dat.
  - rsp_pass != head.qry sets err_r, cleared only by rst.
- Non-query ops produce no response.
- Arithmetic wrap and forwarding are the counter's responsibility. This block never reorders commands.

## Timing
- Reset values:
  - cmd_pass = 0, cmd_op/id/dat = 0.
  - rsp_valid_r = 0, rsp_dat_r = 0.
  - err_r = 0.
  - busy_r = 1 (INIT).
  - All tag pipeline entries have qry = 0.
- Reset released at cycle 0:
  - cmd_pass is high in cycles 1..N with ids 0..N-1.
  - busy_r is low from cycle N; req_ready can first be high in cycle N.
- Transfer at the edge ending cycle T: cmd_pass is high in T+1. For OP_QRY, rsp_pass arrives in T+1+RSP_LAT and rsp_valid_r is high in T+2+RSP_LAT.
- Throughput: one command per cycle, back-to-back across different requesters or the same requester.
- Response path has no backpressure; requesters must accept rsp_valid_r unconditionally.
- rst mid-operation:
  - Discards all in-flight tags.
  - A response arriving later without a tag sets err_r. The counter must be reset together with this block.
- Simultaneous clr and transfer request in RUN: clr wins and no transfer occurs.

## Test plan
- Reset release, N=32: cmd_pass is high for 32 consecutive cycles with ids 0..31, op OP_INIT, dat 0; busy_r falls in cycle 32; no req_ready before then.
- All 4 requesters hold req_valid with OP_INCR: grants go 0,1,2,3,0,… one per cycle; cmd_id follows each requester's req_id.
- Requester 2 sends OP_INIT id 5 dat 7, then requester 1 sends OP_QRY id 5 back-to-back (RSP_LAT=5, stub echoes 7): only rsp_valid_r[1] pulses, with rsp_dat_r = 7, 7 cycles after the query transfer.
- Mixed QRY from requesters 0 and 3 interleaved with INCRs at full rate: each response goes to the issuing requester in issue order; no err_r.
- clr pulsed mid-RUN with 2 queries in flight: both responses are still routed; a fresh 32-cycle INIT walk occurs; req_ready stays 0 until busy_r falls.
- Stub injects a spurious rsp_pass with no query outstanding: err_r goes high the next cycle and stays high until rst.

Source files
------------

// File: rtl/multi_counter_sched.sv
// Front-end scheduler for the multi-counter block: runs the post-reset/clear INIT walk,
// arbitrates R requesters round-robin onto the command port, and routes fixed-latency
// query responses back to their issuers through a tag pipeline.

package multi_counter_variants_pkg;
  typedef enum logic [1:0] {
    OP_INIT = 2'd0,
    OP_INCR = 2'd1,
    OP_ADD  = 2'd2,
    OP_QRY  = 2'd3
  } op_t;
endpackage

module multi_counter_sched
  import multi_counter_variants_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 32,
  parameter int unsigned R       = 4,
  parameter int unsigned RSP_LAT = 5,
  localparam int unsigned IW     = $clog2(N),
  localparam int unsigned RW     = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [R-1:0]          req_valid,
  output logic [R-1:0]          req_ready,
  input  op_t  [R-1:0]          req_op,
  input  logic [R-1:0][IW-1:0]  req_id,
  input  logic [R-1:0][W-1:0]   req_dat,
  output logic                  cmd_pass,
  output op_t                   cmd_op,
  output logic [IW-1:0]         cmd_id,
  output logic [W-1:0]          cmd_dat,
  input  logic                  rsp_pass,
  input  logic [W-1:0]          rsp_dat,
  output logic [R-1:0]          rsp_valid_r,
  output logic [W-1:0]          rsp_dat_r,
  output logic                  busy_r,
  output logic                  err_r
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  typedef struct packed {
    logic          qry;
    logic [RW-1:0] idx;
  } tag_t;

  state_e          state_q, state_d;
  logic [IW-1:0]   init_id_q, init_id_d;
  logic [RW-1:0]   last_grant_q, last_grant_d;

  logic            grant_valid;
  logic [RW-1:0]   grant_idx;

  logic            issue;
  op_t             issue_op;
  logic [IW-1:0]   issue_id;
  logic [W-1:0]    issue_dat;
  logic            issue_qry;

  // Entry 0 rides alongside cmd_*; entry RSP_LAT lines up with rsp_pass.
  tag_t            tag_q [RSP_LAT+1];
  tag_t            head;

  function automatic logic [RW-1:0] rr_idx(logic [RW-1:0] base, int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % R;
    return s[RW-1:0];
  endfunction

  assign head   = tag_q[RSP_LAT];
  assign busy_r = (state_q == StInit);

  // Round-robin search starting just after the last granted requester; clr blocks grants.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state_q == StRun && !clr) begin
      for (int unsigned i = 1; i <= R; i++) begin
        if (!grant_valid && req_valid[rr_idx(last_grant_q, i)]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_idx(last_grant_q, i);
        end
      end
    end
  end

  // One-hot accept for the granted requester.
  always_comb begin
    req_ready = '0;
    if (grant_valid) req_ready[grant_idx] = 1'b1;
  end

  // FSM next state and the command to register this cycle.
  always_comb begin
    state_d      = state_q;
    init_id_d    = init_id_q;
    last_grant_d = last_grant_q;
    issue        = 1'b0;
    issue_op     = OP_INIT;
    issue_id     = '0;
    issue_dat    = '0;
    issue_qry    = 1'b0;
    unique case (state_q)
      StInit: begin
        if (clr) begin
          init_id_d = '0;
        end else begin
          issue    = 1'b1;
          issue_id = init_id_q;
          if (init_id_q == IW'(N - 1)) begin
            init_id_d = '0;
            state_d   = StRun;
          end else begin
            init_id_d = init_id_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (clr) begin
          state_d   = StInit;
          init_id_d = '0;
        end else if (grant_valid) begin
          issue        = 1'b1;
          issue_op     = req_op[grant_idx];
          issue_id     = req_id[grant_idx];
          issue_dat    = req_dat[grant_idx];
          issue_qry    = (req_op[grant_idx] == OP_QRY);
          last_grant_d = grant_idx;
        end
      end
    endcase
  end

  // State, arbitration pointer and registered command port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StInit;
      init_id_q    <= '0;
      last_grant_q <= RW'(R - 1);
      cmd_pass     <= 1'b0;
      cmd_op       <= OP_INIT;
      cmd_id       <= '0;
      cmd_dat      <= '0;
    end else begin
      state_q      <= state_d;
      init_id_q    <= init_id_d;
      last_grant_q <= last_grant_d;
      cmd_pass     <= issue;
      if (issue) begin
        cmd_op  <= issue_op;
        cmd_id  <= issue_id;
        cmd_dat <= issue_dat;
      end
    end
  end

  // Tag shift register; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= RSP_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{qry: issue && issue_qry, idx: grant_idx};
      for (int unsigned i = 1; i <= RSP_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Response routing and sticky tag/response mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= '0;
      rsp_dat_r   <= '0;
      err_r       <= 1'b0;
    end else begin
      rsp_valid_r <= '0;
      if (rsp_pass && head.qry) begin
        rsp_valid_r[head.idx] <= 1'b1;
        rsp_dat_r             <= rsp_dat;
      end
      if (rsp_pass != head.qry) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_counter_sched.sv
// Directed bench for multi_counter_sched with a fixed-latency counter stub.
module tb_multi_counter_sched;
  import multi_counter_variants_pkg::*;

  localparam int unsigned W       = 32;
  localparam int unsigned N       = 32;
  localparam int unsigned R       = 4;
  localparam int unsigned RSP_LAT = 5;
  localparam int unsigned IW      = $clog2(N);

  logic                 clk, rst, clr;
  logic [R-1:0]         req_valid, req_ready;
  op_t  [R-1:0]         req_op;
  logic [R-1:0][IW-1:0] req_id;
  logic [R-1:0][W-1:0]  req_dat;
  logic                 cmd_pass;
  op_t                  cmd_op;
  logic [IW-1:0]        cmd_id;
  logic [W-1:0]         cmd_dat;
  logic                 rsp_pass;
  logic [W-1:0]         rsp_dat;
  logic [R-1:0]         rsp_valid_r;
  logic [W-1:0]         rsp_dat_r;
  logic                 busy_r, err_r;

  int tests = 0;
  int fails = 0;

  // Counter stub: memory plus RSP_LAT-cycle query delay line, with a spurious-pulse hook.
  logic [W-1:0]       mem [N];
  logic [RSP_LAT-1:0] dl_v;
  logic [W-1:0]       dl_d [RSP_LAT];
  logic               inject;

  assign rsp_pass = dl_v[RSP_LAT-1] | inject;
  assign rsp_dat  = dl_d[RSP_LAT-1];

  multi_counter_sched #(.W(W), .N(N), .R(R), .RSP_LAT(RSP_LAT)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .req_dat(req_dat),
    .cmd_pass(cmd_pass), .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_dat(cmd_dat),
    .rsp_pass(rsp_pass), .rsp_dat(rsp_dat),
    .rsp_valid_r(rsp_valid_r), .rsp_dat_r(rsp_dat_r), .busy_r(busy_r), .err_r(err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      dl_v <= '0;
    end else begin
      dl_v[0] <= cmd_pass && (cmd_op == OP_QRY);
      dl_d[0] <= mem[cmd_id];
      for (int k = 1; k < RSP_LAT; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_d[k] <= dl_d[k-1];
      end
    end
    if (cmd_pass) begin
      case (cmd_op)
        OP_INIT: mem[cmd_id] <= cmd_dat;
        OP_INCR: mem[cmd_id] <= mem[cmd_id] + 1;
        OP_ADD:  mem[cmd_id] <= mem[cmd_id] + cmd_dat;
        default: ;
      endcase
    end
  end

  // Mixed-traffic table: requester, op, id, expect response, expected data.
  int unsigned mx_sel [6] = '{0, 0, 3, 1, 3, 0};
  op_t         mx_op  [6] = '{OP_QRY, OP_INCR, OP_QRY, OP_INCR, OP_QRY, OP_QRY};
  int unsigned mx_id  [6] = '{5, 5, 5, 6, 6, 5};
  logic        mx_rv  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int unsigned mx_dat [6] = '{7, 0, 8, 0, 1, 8};

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; inject = 1'b0; req_valid = '0;
    for (int i = 0; i < R; i++) begin
      req_op[i] = OP_INCR; req_id[i] = '0; req_dat[i] = '0;
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    tests++;
    if (cmd_pass !== 1'b0 || cmd_op !== OP_INIT || cmd_id !== '0 || cmd_dat !== '0) begin
      fails++;
      $display("FAIL reset_cmd: got pass=%b op=%0d id=%0d dat=%0h, expected all 0",
               cmd_pass, cmd_op, cmd_id, cmd_dat);
    end
    tests++;
    if (rsp_valid_r !== '0 || rsp_dat_r !== '0 || err_r !== 1'b0 || busy_r !== 1'b1) begin
      fails++;
      $display("FAIL reset_status: got rv=%b rd=%0h err=%b busy=%b, expected 0 0 0 1",
               rsp_valid_r, rsp_dat_r, err_r, busy_r);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    tests++;
    if (cmd_pass !== 1'b0 || req_ready !== '0) begin
      fails++;
      $display("FAIL cycle0: got pass=%b ready=%b, expected 0 0", cmd_pass, req_ready);
    end
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      if (k == N) req_valid = '0;
      @(negedge clk);
      tests++;
      if (cmd_pass !== 1'b1 || cmd_op !== OP_INIT || cmd_id !== IW'(k - 1) || cmd_dat !== '0)
      begin
        fails++;
        $display("FAIL init_walk[%0d]: got pass=%b op=%0d id=%0d dat=%0h, expected 1 0 %0d 0",
                 k, cmd_pass, cmd_op, cmd_id, cmd_dat, k - 1);
      end
      tests++;
      if (busy_r !== (k < N) || req_ready !== '0) begin
        fails++;
        $display("FAIL init_busy[%0d]: got busy=%b ready=%b, expected busy=%b ready=0",
                 k, busy_r, req_ready, (k < N));
      end
    end
  endtask

  task automatic test_round_robin();
    logic [R-1:0] exp_ready;
    for (int i = 0; i < R; i++) begin
      req_op[i] = OP_INCR; req_id[i] = IW'(10 + i); req_dat[i] = '0;
    end
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      req_valid = (j < 8) ? '1 : '0;
      @(negedge clk);
      exp_ready = (j < 8) ? (R'(1) << (j % R)) : '0;
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", j, req_ready, exp_ready);
      end
      if (j > 0) begin
        tests++;
        if (cmd_pass !== 1'b1 || cmd_op !== OP_INCR || cmd_id !== IW'(10 + (j - 1) % R)) begin
          fails++;
          $display("FAIL rr_cmd[%0d]: got pass=%b op=%0d id=%0d expected 1 %0d %0d",
                   j, cmd_pass, cmd_op, cmd_id, OP_INCR, 10 + (j - 1) % R);
        end
      end
    end
  endtask

  task automatic test_init_then_query();
    logic [R-1:0] exp_rv;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_op[2] = OP_INIT; req_id[2] = IW'(5); req_dat[2] = 7;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL iq_grant_init: got %b expected 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b0010; req_op[1] = OP_QRY; req_id[1] = IW'(5);
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL iq_grant_qry: got %b expected 0010", req_ready);
    end
    tests++;
    if (cmd_pass !== 1'b1 || cmd_op !== OP_INIT || cmd_id !== IW'(5) || cmd_dat !== 7) begin
      fails++;
      $display("FAIL iq_cmd_init: got pass=%b op=%0d id=%0d dat=%0d expected 1 0 5 7",
               cmd_pass, cmd_op, cmd_id, cmd_dat);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      if (k == 1) begin
        tests++;
        if (cmd_pass !== 1'b1 || cmd_op !== OP_QRY || cmd_id !== IW'(5)) begin
          fails++;
          $display("FAIL iq_cmd_qry: got pass=%b op=%0d id=%0d expected 1 3 5",
                   cmd_pass, cmd_op, cmd_id);
        end
      end
      exp_rv = (k == 7) ? 4'b0010 : 4'b0000;
      tests++;
      if (rsp_valid_r !== exp_rv || (k == 7 && rsp_dat_r !== 7)) begin
        fails++;
        $display("FAIL iq_rsp[+%0d]: got rv=%b dat=%0d expected rv=%b dat=7",
                 k, rsp_valid_r, rsp_dat_r, exp_rv);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [R-1:0] oh;
    logic [R-1:0] exp_rv;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      req_valid = '0;
      if (c < 6) begin
        req_valid[mx_sel[c]] = 1'b1;
        req_op[mx_sel[c]]    = mx_op[c];
        req_id[mx_sel[c]]    = IW'(mx_id[c]);
      end
      @(negedge clk);
      if (c < 6) begin
        oh = '0; oh[mx_sel[c]] = 1'b1;
        tests++;
        if (req_ready !== oh) begin
          fails++;
          $display("FAIL b2b_grant[%0d]: got %b expected %b", c, req_ready, oh);
        end
      end
      exp_rv = '0;
      if (c >= 7 && mx_rv[c-7]) exp_rv[mx_sel[c-7]] = 1'b1;
      tests++;
      if (rsp_valid_r !== exp_rv || (exp_rv != '0 && rsp_dat_r !== mx_dat[c-7])) begin
        fails++;
        $display("FAIL b2b_rsp[%0d]: got rv=%b dat=%0d expected rv=%b dat=%0d", c,
                 rsp_valid_r, rsp_dat_r, exp_rv, (c >= 7) ? mx_dat[c-7] : 0);
      end
    end
    tests++;
    if (err_r !== 1'b0) begin
      fails++;
      $display("FAIL b2b_err: got %b expected 0", err_r);
    end
  endtask

  task automatic test_clr_inflight();
    logic [R-1:0] exp_ready, exp_rv;
    for (int c = 0; c < 37; c++) begin
      @(posedge clk); #1;
      clr = (c == 2);
      case (c)
        0:       begin req_valid = 4'b0001; req_op[0] = OP_QRY; req_id[0] = IW'(5); end
        1:       begin req_valid = 4'b1000; req_op[3] = OP_QRY; req_id[3] = IW'(6); end
        2:       begin req_valid = 4'b0010; req_op[1] = OP_INCR; req_id[1] = IW'(9); end
        36:      req_valid = '0;
        default: ;
      endcase
      @(negedge clk);
      exp_ready = (c == 0) ? 4'b0001 : (c == 1) ? 4'b1000 : (c == 35) ? 4'b0010 : 4'b0000;
      tests++;
      if (req_ready !== exp_ready) begin
        fails++;
        $display("FAIL clr_ready[%0d]: got %b expected %b", c, req_ready, exp_ready);
      end
      if (c >= 3) begin
        tests++;
        if (busy_r !== (c < 35)) begin
          fails++;
          $display("FAIL clr_busy[%0d]: got %b expected %b", c, busy_r, (c < 35));
        end
      end
      if (c == 3) begin
        tests++;
        if (cmd_pass !== 1'b0) begin
          fails++;
          $display("FAIL clr_gap: got cmd_pass=%b expected 0", cmd_pass);
        end
      end
      if (c >= 4 && c <= 35) begin
        tests++;
        if (cmd_pass !== 1'b1 || cmd_op !== OP_INIT || cmd_id !== IW'(c - 4) || cmd_dat !== '0)
        begin
          fails++;
          $display("FAIL clr_walk[%0d]: got pass=%b op=%0d id=%0d expected 1 0 %0d",
                   c, cmd_pass, cmd_op, cmd_id, c - 4);
        end
      end
      exp_rv = (c == 7) ? 4'b0001 : (c == 8) ? 4'b1000 : 4'b0000;
      tests++;
      if (rsp_valid_r !== exp_rv || (c == 7 && rsp_dat_r !== 8) || (c == 8 && rsp_dat_r !== 1))
      begin
        fails++;
        $display("FAIL clr_rsp[%0d]: got rv=%b dat=%0d expected rv=%b",
                 c, rsp_valid_r, rsp_dat_r, exp_rv);
      end
    end
    tests++;
    if (err_r !== 1'b0) begin
      fails++;
      $display("FAIL clr_err: got %b expected 0", err_r);
    end
  endtask

  task automatic test_spurious_err();
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    tests++;
    if (err_r !== 1'b0) begin
      fails++;
      $display("FAIL spur_pre: got err=%b expected 0", err_r);
    end
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    tests++;
    if (err_r !== 1'b1 || rsp_valid_r !== '0) begin
      fails++;
      $display("FAIL spur_set: got err=%b rv=%b expected err=1 rv=0", err_r, rsp_valid_r);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (err_r !== 1'b1) begin
        fails++;
        $display("FAIL spur_sticky[%0d]: got err=%b expected 1", k, err_r);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (err_r !== 1'b0 || busy_r !== 1'b1) begin
      fails++;
      $display("FAIL spur_rst: got err=%b busy=%b expected err=0 busy=1", err_r, busy_r);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_init_then_query();
    test_back_to_back();
    test_clr_inflight();
    test_spurious_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
